// File: rtl/pc_sequencer_if.sv
// Bundle of fetch-side and branch-side signals that connect the PC sequencer
// to the branch unit, the instruction memory and the downstream pipeline.
interface pc_sequencer_if;
    logic        stall;
    logic        br_valid;
    logic        br_uncond;
    logic        br_zero;
    logic [11:0] br_target;
    logic        imem_ack;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [11:0] pc;
    logic        brcond;
    logic        fetch_valid;
    logic        flush;

    // Sequencer side
    modport master (
        input  stall,
        input  br_valid,
        input  br_uncond,
        input  br_zero,
        input  br_target,
        input  imem_ack,
        output imem_req,
        output imem_addr,
        output pc,
        output brcond,
        output fetch_valid,
        output flush
    );

    // Environment side: branch unit, instruction memory and pipeline
    modport slave (
        output stall,
        output br_valid,
        output br_uncond,
        output br_zero,
        output br_target,
        output imem_ack,
        input  imem_req,
        input  imem_addr,
        input  pc,
        input  brcond,
        input  fetch_valid,
        input  flush
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues instruction fetches, steps the PC, and
// applies resolved branches, deferring a redirect while a fetch is outstanding.
module pc_sequencer #(
    parameter logic [11:0] RESET_PC = 12'd0,
    parameter logic [11:0] PC_STEP  = 12'd4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] redir_q, redir_d;

    logic        brcond;
    logic [11:0] pcInc;
    logic [11:0] nextPc;
    logic        imemReq;
    logic        fetchValid;
    logic        flush;

    assign brcond = bus.br_valid & (bus.br_uncond | bus.br_zero);
    assign pcInc  = pc_q + PC_STEP;
    assign nextPc = brcond ? bus.br_target : pcInc;

    // Outputs are decoded from the registered state, so reset reaches them
    // only through the state register.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        imemReq    = 1'b0;
        fetchValid = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                imemReq = 1'b1;
                if (bus.imem_ack) begin
                    pc_d       = nextPc;
                    fetchValid = ~brcond;
                    flush      = brcond;
                    state_d    = bus.stall ? STALL : FETCH;
                end else if (brcond) begin
                    redir_d = bus.br_target;
                    state_d = REDIRECT;
                end
            end

            REDIRECT: begin
                // Request stays on the old PC until acked; a branch arriving
                // with the ack wins over the saved target.
                imemReq = 1'b1;
                if (bus.imem_ack) begin
                    pc_d    = brcond ? bus.br_target : redir_q;
                    flush   = 1'b1;
                    state_d = bus.stall ? STALL : FETCH;
                end else if (brcond) begin
                    redir_d = bus.br_target;
                end
            end

            STALL: begin
                if (brcond) begin
                    pc_d  = bus.br_target;
                    flush = 1'b1;
                end
                state_d = bus.stall ? STALL : FETCH;
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            redir_q <= 12'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.brcond      = brcond;
    assign bus.fetch_valid = fetchValid;
    assign bus.flush       = flush;

    // An outstanding request must keep its address until the memory takes it.
    reqHeldUntilAck: assert property (
        @(posedge clk) disable iff (reset)
        (imemReq && !bus.imem_ack) |=> (imemReq && $stable(pc_q))
    );

    validFlushExclusive: assert property (
        @(posedge clk) disable iff (reset)
        !(fetchValid && flush)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a vector table plus hand-built multi-cycle sequences,
// with post-edge PC expectations queued at drive time and checked after the edge.
module tb_pc_sequencer;

    typedef struct {
        logic        stall;
        logic        bv;
        logic        bu;
        logic        bz;
        logic [11:0] tgt;
        logic        ack;
        logic        eReq;
        logic        eFv;
        logic        eFl;
        logic        eBrc;
        logic [11:0] ePc;
        logic [11:0] eNext;
    } vec_t;

    typedef struct {
        string       tag;
        logic [11:0] pc;
    } sbEntry_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sbEntry_t sb[$];
    vec_t     vecs[21];

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC (12'd0),
        .PC_STEP  (12'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic bv, input logic bu,
                                input logic bz, input logic [11:0] t, input logic a,
                                input logic r, input logic fv, input logic fl,
                                input logic bc, input logic [11:0] p,
                                input logic [11:0] n);
        vec_t v;
        v.stall = s;  v.bv = bv;   v.bu = bu;   v.bz = bz;
        v.tgt   = t;  v.ack = a;   v.eReq = r;  v.eFv = fv;
        v.eFl   = fl; v.eBrc = bc; v.ePc = p;   v.eNext = n;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset         = 1'b0;
        bus.stall     = v.stall;
        bus.br_valid  = v.bv;
        bus.br_uncond = v.bu;
        bus.br_zero   = v.bz;
        bus.br_target = v.tgt;
        bus.imem_ack  = v.ack;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] act,
                               input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic popAndCheck();
        sbEntry_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            checkOutput($sformatf("%s.pcNext", e.tag), bus.pc, e.pc);
        end
    endtask

    // One clock: drive at the falling edge, check combinational outputs just
    // after, then check the registered PC just after the rising edge.
    task automatic stepCycle(input vec_t v, input string tag);
        sbEntry_t e;
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput($sformatf("%s.req", tag),  {11'd0, bus.imem_req},    {11'd0, v.eReq});
        checkOutput($sformatf("%s.fv", tag),   {11'd0, bus.fetch_valid}, {11'd0, v.eFv});
        checkOutput($sformatf("%s.fl", tag),   {11'd0, bus.flush},       {11'd0, v.eFl});
        checkOutput($sformatf("%s.brc", tag),  {11'd0, bus.brcond},      {11'd0, v.eBrc});
        checkOutput($sformatf("%s.pc", tag),   bus.pc,        v.ePc);
        checkOutput($sformatf("%s.addr", tag), bus.imem_addr, v.ePc);
        e.tag = tag;
        e.pc  = v.eNext;
        sb.push_back(e);
        @(posedge clk);
        #1;
        popAndCheck();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //             s  bv bu bz tgt      ack  req fv fl brc pc       next
        vecs[0]  = mk(0, 0, 0, 0, 12'h000, 1,   0,  0, 0, 0,  12'h000, 12'h000);
        vecs[1]  = mk(0, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h000, 12'h004);
        vecs[2]  = mk(0, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h004, 12'h008);
        vecs[3]  = mk(0, 1, 0, 0, 12'h300, 1,   1,  1, 0, 0,  12'h008, 12'h00C);
        vecs[4]  = mk(0, 1, 0, 1, 12'h040, 1,   1,  0, 1, 1,  12'h00C, 12'h040);
        vecs[5]  = mk(0, 0, 0, 0, 12'h000, 0,   1,  0, 0, 0,  12'h040, 12'h040);
        vecs[6]  = mk(1, 0, 0, 0, 12'h000, 0,   1,  0, 0, 0,  12'h040, 12'h040);
        vecs[7]  = mk(1, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h040, 12'h044);
        vecs[8]  = mk(1, 0, 0, 0, 12'h000, 0,   0,  0, 0, 0,  12'h044, 12'h044);
        vecs[9]  = mk(1, 1, 1, 0, 12'h080, 0,   0,  0, 1, 1,  12'h044, 12'h080);
        vecs[10] = mk(0, 0, 0, 0, 12'h000, 0,   0,  0, 0, 0,  12'h080, 12'h080);
        vecs[11] = mk(0, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h080, 12'h084);
        vecs[12] = mk(0, 1, 1, 0, 12'h100, 0,   1,  0, 0, 1,  12'h084, 12'h084);
        vecs[13] = mk(0, 1, 1, 0, 12'h200, 0,   1,  0, 0, 1,  12'h084, 12'h084);
        vecs[14] = mk(0, 0, 0, 0, 12'h000, 0,   1,  0, 0, 0,  12'h084, 12'h084);
        vecs[15] = mk(0, 0, 0, 0, 12'h000, 1,   1,  0, 1, 0,  12'h084, 12'h200);
        vecs[16] = mk(0, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h200, 12'h204);
        vecs[17] = mk(0, 1, 0, 1, 12'h010, 0,   1,  0, 0, 1,  12'h204, 12'h204);
        vecs[18] = mk(1, 1, 1, 0, 12'h020, 1,   1,  0, 1, 1,  12'h204, 12'h020);
        vecs[19] = mk(0, 0, 0, 0, 12'h000, 0,   0,  0, 0, 0,  12'h020, 12'h020);
        vecs[20] = mk(0, 0, 0, 0, 12'h000, 1,   1,  1, 0, 0,  12'h020, 12'h024);

        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.br_valid  = 1'b0;
        bus.br_uncond = 1'b0;
        bus.br_zero   = 1'b0;
        bus.br_target = 12'h000;
        bus.imem_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.pc",  bus.pc, 12'h000);
        checkOutput("reset.req", {11'd0, bus.imem_req},    12'd0);
        checkOutput("reset.fv",  {11'd0, bus.fetch_valid}, 12'd0);
        checkOutput("reset.fl",  {11'd0, bus.flush},       12'd0);

        for (int i = 0; i < 21; i++) begin
            stepCycle(vecs[i], $sformatf("vec%0d", i));
        end

        // Wrap from 0xFFC to 0x000
        stepCycle(mk(0, 1, 1, 0, 12'hFFC, 1, 1, 0, 1, 1, 12'h024, 12'hFFC), "wrapBr");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 1, 1, 0, 0, 12'hFFC, 12'h000), "wrap");

        // Two branches while fetch at 16 is outstanding; newest target wins
        stepCycle(mk(0, 1, 1, 0, 12'h010, 1, 1, 0, 1, 1, 12'h000, 12'h010), "rdTo16");
        stepCycle(mk(0, 1, 1, 0, 12'h100, 0, 1, 0, 0, 1, 12'h010, 12'h010), "rdB100");
        stepCycle(mk(0, 1, 1, 0, 12'h200, 0, 1, 0, 0, 1, 12'h010, 12'h010), "rdB200");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 0, 1, 0, 0, 0, 12'h010, 12'h010), "rdWait");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 1, 0, 1, 0, 12'h010, 12'h200), "rdAck");

        // Stall during ack at 20, branch taken while stalled, resume at target
        stepCycle(mk(0, 1, 1, 0, 12'h014, 1, 1, 0, 1, 1, 12'h200, 12'h014), "stTo20");
        stepCycle(mk(1, 0, 0, 0, 12'h000, 1, 1, 1, 0, 0, 12'h014, 12'h018), "stAck");
        stepCycle(mk(1, 0, 0, 0, 12'h000, 1, 0, 0, 0, 0, 12'h018, 12'h018), "stHold");
        stepCycle(mk(1, 1, 1, 0, 12'h080, 0, 0, 0, 1, 1, 12'h018, 12'h080), "stBr");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 12'h080, 12'h080), "stRel");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 1, 1, 0, 0, 12'h080, 12'h084), "stRes");

        // Reset while a redirect is pending; saved target must be lost
        stepCycle(mk(0, 1, 1, 0, 12'h0F0, 0, 1, 0, 0, 1, 12'h084, 12'h084), "rstRd");
        @(negedge clk);
        reset         = 1'b1;
        bus.br_valid  = 1'b0;
        bus.imem_ack  = 1'b0;
        #1;
        checkOutput("rstMid.req", {11'd0, bus.imem_req}, 12'd1);
        @(posedge clk);
        #1;
        checkOutput("rstMid.pc",  bus.pc, 12'h000);
        checkOutput("rstMid.req", {11'd0, bus.imem_req}, 12'd0);
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 0, 0, 0, 0, 12'h000, 12'h000), "rstBoot");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 1, 1, 0, 0, 12'h000, 12'h004), "rstF0");
        stepCycle(mk(0, 0, 0, 0, 12'h000, 1, 1, 1, 0, 0, 12'h004, 12'h008), "rstF1");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboardDrain: got %0d left expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
